evm_tick_sched: RTL
===================

# evm_tick_sched

Shared timebase and timeout scheduler for the EVM datapath. A single prescaler derives a millisecond tick, a one-second pulse and a 1 Hz blink level from the 50 MHz system clock. It arbitrates that one timebase among NCH independent countdown channels (vote-window, button debounce-hold, display refresh, lockout). Consumers use one-cycle enables from this block instead of locally divided clocks.

## Interface
- CLK_HZ, 50000000, system clock frequency
- TICK_HZ, 1000, tick rate; DIV = CLK_HZ/TICK_HZ, must be integer and >= 2
- NCH, 4, number of timeout channels
- CW, 16, timeout count width (ticks)
- clk_50m  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  global run; low freezes prescaler and all channels
- tick_ms  out  1  one-cycle pulse every DIV enabled cycles
- sec_pulse  out  1  one-cycle pulse, coincident with every TICK_HZ-th tick_ms
- blink  out  1  level, toggles on each sec_pulse
- start  in  NCH  per-channel load/restart request, level-sampled each cycle
- cancel  in  NCH  per-channel abort request
- load_val  in  NCH*CW  channel i timeout in ticks at bits [i*CW +: CW]
- busy  out  NCH  channel i in RUN
- expire  out  NCH  one-cycle pulse when channel i times out

## Operation
- Prescaler pcnt (0..DIV-1), increments while en=1. At DIV-1 it wraps to 0, and tick_ms is registered high for the next cycle. Holds while en=0.
- Tick counter mcnt (0..TICK_HZ-1) advances on each tick. sec_pulse is asserted in the same cycle as the tick that completes mcnt=TICK_HZ-1, then mcnt wraps. blink toggles in the cycle after sec_pulse.
- Each channel has states IDLE, RUN, EXP and a CW-bit counter rem. All channels share the same tick_ms.
- Priority per channel, per cycle: rst > cancel > start > tick decrement.
- cancel (any state): next state IDLE; rem unchanged (don't-care).
- start with load_val=0: next state EXP (expire next cycle, no RUN).
- start with load_val>0: next state RUN, rem=load_val. This restarts a channel already in RUN or EXP. A tick in the same cycle is not counted.
- RUN with tick_ms=1 and en=1:
  - If rem==1, next state EXP.
  - Otherwise rem=rem-1.
- EXP lasts exactly one cycle, then IDLE unless restarted.
- busy[i] = (state==RUN); expire[i] = (state==EXP). Both are decoded from registered state, so they are glitch-free.
- en=0: state and rem hold. start/cancel are still honoured (load/abort immediately), but no decrements occur. An EXP reached before en dropped still pulses once.
- Channels are fully independent; simultaneous expiries on several channels are allowed.

## Timing
- Reset values: pcnt=0, mcnt=0, tick_ms=0, sec_pulse=0, blink=0, all channels IDLE, busy=0, expire=0.
- First tick_ms is high in the cycle after the DIV-th enabled rising edge following reset release. Subsequent ticks are exactly DIV enabled cycles apart.
- Timeout N>0: expire is high the cycle after the N-th tick_ms following the start cycle. Wall delay is between (N-1)*DIV+1 and N*DIV cycles, plus 1 registration cycle.
- busy rises the cycle after start. busy falls in the same cycle expire rises.
- Reset mid-run aborts every channel with no expire pulse and restarts the timebase phase.
- rem never wraps: decrement only occurs from rem>=2.

## Test plan
- Timebase, with CLK_HZ=20, TICK_HZ=4 (DIV=5), en=1 after reset: tick_ms high on cycles 6, 11, 16, 21; sec_pulse with the 4th tick (cycle 21); blink=1 from cycle 22.
- Basic timeout: start[0] with load_val=3 at cycle 2. busy[0]=1 from cycle 3; expire[0] one cycle after the 3rd tick (cycle 17); busy[0]=0 at 17.
- Cancel/collision cases:
  - start[1]=load 2, then cancel[1] before the 2nd tick: busy drops next cycle, expire never asserts.
  - start and cancel in the same cycle: channel stays IDLE.
- Restart and zero: re-start ch2 (load 4) while in RUN with rem=1: expire deferred by 4 more ticks. start ch3 with load_val=0: expire[3] next cycle, busy[3] never set.
- Freeze: drop en for 50 cycles mid-run: no tick_ms, rem and pcnt hold, and the remaining delay resumes exactly on en=1.
- Reset mid-operation: rst while channels run: all outputs 0 next cycle; first tick after release again on the 5th enabled edge.

Source files
------------

// File: rtl/evm_tick_sched.sv
// evm_tick_sched: shared ms/second timebase and NCH countdown channels.
// All consumers get one-cycle enables; no derived clocks leave this block.
module evm_tick_sched #(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 1000,
    parameter int NCH     = 4,
    parameter int CW      = 16
) (
    input  logic            clk_50m,
    input  logic            rst,
    input  logic            en,
    output logic            tick_ms,
    output logic            sec_pulse,
    output logic            blink,
    input  logic [NCH-1:0]  start,
    input  logic [NCH-1:0]  cancel,
    input  logic [NCH*CW-1:0] load_val,
    output logic [NCH-1:0]  busy,
    output logic [NCH-1:0]  expire
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int MW  = (TICK_HZ > 1) ? $clog2(TICK_HZ) : 1;

    localparam logic [PW-1:0] PMAX    = PW'(DIV - 1);
    localparam logic [MW-1:0] MMAX    = MW'(TICK_HZ - 1);
    localparam logic [CW-1:0] REM_ONE = CW'(1);

    typedef enum logic [1:0] {
        CH_IDLE = 2'd0,
        CH_RUN  = 2'd1,
        CH_EXP  = 2'd2
    } ch_state_e;

    logic [PW-1:0] pcnt;
    logic [MW-1:0] mcnt;
    logic          wrap;
    logic          dec_ok;

    ch_state_e     state_q [NCH];
    ch_state_e     state_d [NCH];
    logic [CW-1:0] rem_q   [NCH];
    logic [CW-1:0] rem_d   [NCH];

    // Prescaler wraps on its last enabled count; tick is registered from it.
    assign wrap = en && (pcnt == PMAX);

    // Channels only decrement on a tick seen while the timebase runs.
    assign dec_ok = tick_ms && en;

    // Prescaler, tick counter and the registered tick/second pulses.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            pcnt      <= '0;
            mcnt      <= '0;
            tick_ms   <= 1'b0;
            sec_pulse <= 1'b0;
        end else begin
            tick_ms   <= wrap;
            sec_pulse <= wrap && (mcnt == MMAX);
            if (en) begin
                pcnt <= wrap ? '0 : pcnt + 1'b1;
            end
            if (wrap) begin
                mcnt <= (mcnt == MMAX) ? '0 : mcnt + 1'b1;
            end
        end
    end

    // Blink level flips the cycle after each second pulse.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            blink <= 1'b0;
        end else begin
            blink <= blink ^ sec_pulse;
        end
    end

    // Channel state and remaining-tick registers.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= CH_IDLE;
                rem_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                rem_q[i]   <= rem_d[i];
            end
        end
    end

    // Per-channel next state: cancel beats start beats tick decrement.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            rem_d[i]   = rem_q[i];
            if (cancel[i]) begin
                state_d[i] = CH_IDLE;
            end else if (start[i]) begin
                if (load_val[i*CW +: CW] == '0) begin
                    state_d[i] = CH_EXP;
                end else begin
                    state_d[i] = CH_RUN;
                    rem_d[i]   = load_val[i*CW +: CW];
                end
            end else begin
                unique case (state_q[i])
                    CH_RUN: begin
                        if (dec_ok) begin
                            if (rem_q[i] <= REM_ONE) begin
                                state_d[i] = CH_EXP;
                            end else begin
                                rem_d[i] = rem_q[i] - 1'b1;
                            end
                        end
                    end
                    CH_EXP: begin
                        state_d[i] = CH_IDLE;
                    end
                    default: begin
                        state_d[i] = CH_IDLE;
                    end
                endcase
            end
        end
    end

    // Status outputs decoded straight from registered state.
    always_comb begin
        busy   = '0;
        expire = '0;
        for (int i = 0; i < NCH; i++) begin
            busy[i]   = (state_q[i] == CH_RUN);
            expire[i] = (state_q[i] == CH_EXP);
        end
    end

endmodule
